sram_port_arbiter: RTL and testbench
====================================

Name: sram_port_arbiter

Overview:
- Shares one SRAM-like memory port (req/addr_ok/data_ok handshake) between the instruction-fetch requester (IF) and the data requester (EXE/MEM load/store path).
- Sits between the pipeline and the downstream memory bridge.
- Tracks outstanding transactions in order, routes each response back to the requester that issued it, and discards responses for fetches cancelled by a pipeline flush.

Parameters:
- OUTST, 2, maximum outstanding accepted-but-unanswered transactions (1..4).
- AW, 32, address width.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- i_req  in  1  inst request
- i_addr  in  AW  inst address (read-only, size fixed 2'd2)
- i_addr_ok  out  1  inst address accepted
- i_data_ok  out  1  inst read data valid
- i_rdata  out  32  inst read data
- i_cancel  in  1  flush: drop responses of all inst transactions outstanding at this edge
- d_req  in  1  data request
- d_wr  in  1  1=store
- d_size  in  2  0=byte, 1=half, 2=word
- d_addr  in  AW  data address
- d_wstrb  in  4  byte strobes
- d_wdata  in  32  store data
- d_addr_ok  out  1  data address accepted
- d_data_ok  out  1  data response (load data or store ack)
- d_rdata  out  32  load data
- m_req, m_wr, m_size, m_addr, m_wstrb, m_wdata  out  1/1/2/AW/4/32  downstream request
- m_addr_ok  in  1  downstream accept
- m_data_ok  in  1  downstream response, in request order
- m_rdata  in  32  downstream read data
- busy  out  1  at least one transaction outstanding

Behaviour:
- Reset: FIFO empty; count=0; lock cleared; all discard bits 0; every output 0.
- Arbitration (combinational, current cycle):
  - Fixed priority: data > inst.
  - No grant when count==OUTST. A pop in the same cycle does not free a slot until the next cycle.
- Lock:
  - If m_req=1 and m_addr_ok=0, the granted requester keeps the grant next cycle, even if the other requester raises req. The downstream request fields must stay stable.
  - Lock clears on m_addr_ok or when the granted requester drops req.
  - Requesters must hold req and fields until addr_ok.
- m_* mirrors the granted requester's fields. For inst: m_wr=0, m_size=2, m_wstrb=0.
- x_addr_ok = grant_x & m_addr_ok. Zero latency from m_addr_ok.
- Accept (m_req & m_addr_ok): push {id, discard=0} into the ID FIFO; count+1.
- Response (m_data_ok & count!=0):
  - Pop the FIFO head; count-1.
  - If head id=data: d_data_ok=1, d_rdata=m_rdata.
  - If head id=inst and discard=0: i_data_ok=1, i_rdata=m_rdata.
  - If head id=inst and discard=1: swallowed, no output pulse.
  - Response latency is combinational pass-through from m_data_ok.
- Simultaneous accept and response: push and pop both occur; count unchanged.
- m_data_ok with count==0: ignored. This is a protocol error and is flagged by a bench assertion.
- i_cancel:
  - Sets discard on every valid inst entry, including the head being popped in the same cycle. That head's response is swallowed.
  - A fetch accepted in the same cycle as i_cancel is also marked discard.
  - Data entries are never affected.
- x_rdata is 0 when the matching x_data_ok=0.
- busy = (count!=0).
- Reset mid-transaction: the FIFO is cleared. The downstream bridge is reset in the same cycle, so no stale m_data_ok is expected.

Optional Feature:
- Macro ARB_ROUND_ROBIN_EN.
- Defined:
  - Priority alternates on each accepted transaction: a last_grant flop (reset=inst, so data wins first) gives the next tie to the other requester.
  - Lock rules are unchanged.
- Undefined: fixed data>inst priority and no last_grant flop.

Decomposition:
- Shared defines header: requester ID encoding (ARB_ID_INST=0, ARB_ID_DATA=1), size encodings, ARB_FIFO_ENTRY_WD=2.
- One natural sub-module: arb_id_fifo.
  - OUTST-deep circular buffer of {discard,id}.
  - push/pop/cancel_inst ports, count and head outputs.
  - Pointer wrap at OUTST.

Test Plan:
- Only d_req=1, d_addr=0x1000, m_addr_ok=1 same cycle, m_data_ok 2 cycles later with m_rdata=0xDEADBEEF -> d_addr_ok pulses once; d_data_ok=1 with d_rdata=0xDEADBEEF; i_* outputs stay 0.
- i_req and d_req both high, m_addr_ok=1 every cycle -> data accepted first, inst next cycle; responses route data then inst. With ARB_ROUND_ROBIN_EN, repeated contention alternates D,I,D,I.
- Inst granted, m_addr_ok held 0 for 3 cycles while d_req rises -> m_addr stays the inst address and m_wr=0 throughout; data is granted only after inst addr_ok.
- Issue 2 fetches (OUTST=2) with m_data_ok withheld, then raise d_req -> d_addr_ok stays 0 until the first m_data_ok; no grant in the pop cycle, grant the cycle after.
- 2 fetches outstanding, i_cancel pulse, then 2 m_data_ok (0x11, 0x22) -> no i_data_ok pulses; count returns to 0. A new fetch's response 0x33 is delivered.
- Reset asserted with 2 outstanding -> next cycle busy=0, all outputs 0, first subsequent request is accepted normally.

Source files
------------

// File: rtl/sram_port_arbiter_pkg.sv
// Shared encodings for the SRAM port arbiter: requester IDs, access sizes,
// ID FIFO entry layout and the downstream control bundle.
package sram_port_arbiter_pkg;

    localparam logic       ARB_ID_INST       = 1'b0;
    localparam logic       ARB_ID_DATA       = 1'b1;

    localparam logic [1:0] ARB_SIZE_BYTE     = 2'd0;
    localparam logic [1:0] ARB_SIZE_HALF     = 2'd1;
    localparam logic [1:0] ARB_SIZE_WORD     = 2'd2;

    localparam int         ARB_FIFO_ENTRY_WD = 2;

    // One in-flight transaction: who issued it and whether its answer is dropped.
    typedef struct packed {
        logic discard;
        logic id;
    } arb_entry_t;

    // Non-address request fields that travel with a downstream request.
    typedef struct packed {
        logic        wr;
        logic [1:0]  size;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
    } arb_ctl_t;

    // Pointer width for a circular buffer of the given depth (at least 1 bit).
    function automatic int arb_ptr_wd(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/sram_port_arbiter_arb_id_fifo.sv
// In-order ID FIFO for the SRAM port arbiter. Holds {discard,id} for every
// accepted-but-unanswered transaction; cancel_inst marks all inst entries.
module sram_port_arbiter_arb_id_fifo
    import sram_port_arbiter_pkg::*;
#(
    parameter int OUTST = 2,
    parameter int CW    = $clog2(OUTST + 1)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            push,
    input  arb_entry_t      push_entry,
    input  logic            pop,
    input  logic            cancel_inst,
    output logic [CW-1:0]   count,
    output arb_entry_t      head
);

    localparam int PW = arb_ptr_wd(OUTST);

    arb_entry_t      mem [OUTST];
    logic [PW-1:0]   wptr;
    logic [PW-1:0]   rptr;
    logic            push_ok;
    logic            pop_ok;

    // Advance a pointer, wrapping at OUTST so non-power-of-two depths work.
    function automatic logic [PW-1:0] ptr_nxt(input logic [PW-1:0] p);
        return (p == PW'(OUTST - 1)) ? '0 : p + 1'b1;
    endfunction

    assign push_ok = push & (count != CW'(OUTST));
    assign pop_ok  = pop  & (count != '0);
    assign head    = mem[rptr];

    // Storage, pointers and occupancy; cancel first so a same-cycle push wins its slot.
    always_ff @(posedge clk) begin
        if (reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            for (int i = 0; i < OUTST; i++) mem[i] <= '0;
        end else begin
            if (cancel_inst) begin
                for (int i = 0; i < OUTST; i++)
                    if (mem[i].id == ARB_ID_INST) mem[i].discard <= 1'b1;
            end
            if (push_ok) begin
                mem[wptr] <= push_entry;
                wptr      <= ptr_nxt(wptr);
            end
            if (pop_ok) rptr <= ptr_nxt(rptr);
            count <= count + CW'(push_ok) - CW'(pop_ok);
        end
    end

endmodule

// File: rtl/sram_port_arbiter.sv
// SRAM-like port arbiter: shares one req/addr_ok/data_ok port between the
// instruction fetch and data requesters, routes responses back in order and
// swallows responses of fetches cancelled by a flush.
// Optional: define ARB_ROUND_ROBIN_EN to alternate priority on each accept.
module sram_port_arbiter
    import sram_port_arbiter_pkg::*;
#(
    parameter int OUTST = 2,
    parameter int AW    = 32
) (
    input  logic          clk,
    input  logic          reset,

    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic          i_addr_ok,
    output logic          i_data_ok,
    output logic [31:0]   i_rdata,
    input  logic          i_cancel,

    input  logic          d_req,
    input  logic          d_wr,
    input  logic [1:0]    d_size,
    input  logic [AW-1:0] d_addr,
    input  logic [3:0]    d_wstrb,
    input  logic [31:0]   d_wdata,
    output logic          d_addr_ok,
    output logic          d_data_ok,
    output logic [31:0]   d_rdata,

    output logic          m_req,
    output logic          m_wr,
    output logic [1:0]    m_size,
    output logic [AW-1:0] m_addr,
    output logic [3:0]    m_wstrb,
    output logic [31:0]   m_wdata,
    input  logic          m_addr_ok,
    input  logic          m_data_ok,
    input  logic [31:0]   m_rdata,

    output logic          busy
);

    localparam int CW = $clog2(OUTST + 1);

    logic [CW-1:0] count;
    arb_entry_t    head;
    arb_entry_t    push_entry;
    logic          full;
    logic          lock_q;
    logic          lock_id_q;
    logic          lock_hold;
    logic          data_wins;
    logic          grant_d;
    logic          grant_i;
    logic          gnt_id;
    logic          accept;
    logic          pop;
    logic          head_drop;
    arb_ctl_t      d_ctl;
    arb_ctl_t      m_ctl;

    assign full      = (count == CW'(OUTST));
    // A stalled request keeps its grant only while its owner still asks.
    assign lock_hold = lock_q & ((lock_id_q == ARB_ID_DATA) ? d_req : i_req);

`ifdef ARB_ROUND_ROBIN_EN
    logic last_grant_q;

    assign data_wins = ~i_req | (last_grant_q == ARB_ID_INST);

    // Remember who was accepted last so the next tie goes to the other side.
    always_ff @(posedge clk) begin
        if (reset)       last_grant_q <= ARB_ID_INST;
        else if (accept) last_grant_q <= gnt_id;
    end
`else
    assign data_wins = 1'b1;
`endif

    // Grant selection: lock first, then priority; nothing while the FIFO is full.
    always_comb begin
        grant_d = 1'b0;
        grant_i = 1'b0;
        if (!full) begin
            if (lock_hold) begin
                grant_d = (lock_id_q == ARB_ID_DATA);
                grant_i = (lock_id_q == ARB_ID_INST);
            end else begin
                grant_d = d_req & data_wins;
                grant_i = i_req & ~grant_d;
            end
        end
    end

    assign gnt_id = grant_d ? ARB_ID_DATA : ARB_ID_INST;
    assign d_ctl  = '{wr: d_wr, size: d_size, wstrb: d_wstrb, wdata: d_wdata};

    // Downstream request mirrors the granted requester; fetches are fixed word reads.
    always_comb begin
        m_req  = 1'b0;
        m_addr = '0;
        m_ctl  = '0;
        if (grant_d) begin
            m_req  = 1'b1;
            m_addr = d_addr;
            m_ctl  = d_ctl;
        end else if (grant_i) begin
            m_req  = 1'b1;
            m_addr = i_addr;
            m_ctl  = '{wr: 1'b0, size: ARB_SIZE_WORD, wstrb: 4'h0, wdata: 32'h0};
        end
    end

    assign m_wr    = m_ctl.wr;
    assign m_size  = m_ctl.size;
    assign m_wstrb = m_ctl.wstrb;
    assign m_wdata = m_ctl.wdata;

    assign accept    = m_req & m_addr_ok;
    assign i_addr_ok = grant_i & m_addr_ok;
    assign d_addr_ok = grant_d & m_addr_ok;

    // Hold the grant across addr_ok stalls so downstream fields stay stable.
    always_ff @(posedge clk) begin
        if (reset) begin
            lock_q    <= 1'b0;
            lock_id_q <= ARB_ID_INST;
        end else if (m_req && !m_addr_ok) begin
            lock_q    <= 1'b1;
            lock_id_q <= gnt_id;
        end else begin
            lock_q    <= 1'b0;
        end
    end

    // A fetch accepted alongside a flush is already stale.
    assign push_entry = '{discard: i_cancel & (gnt_id == ARB_ID_INST), id: gnt_id};

    sram_port_arbiter_arb_id_fifo #(
        .OUTST (OUTST),
        .CW    (CW)
    ) u_arb_id_fifo (
        .clk         (clk),
        .reset       (reset),
        .push        (accept),
        .push_entry  (push_entry),
        .pop         (pop),
        .cancel_inst (i_cancel),
        .count       (count),
        .head        (head)
    );

    assign pop       = m_data_ok & (count != '0);
    // The flush also covers the fetch whose answer arrives this very cycle.
    assign head_drop = head.discard | i_cancel;
    assign i_data_ok = pop & (head.id == ARB_ID_INST) & ~head_drop;
    assign d_data_ok = pop & (head.id == ARB_ID_DATA);
    assign i_rdata   = i_data_ok ? m_rdata : 32'h0;
    assign d_rdata   = d_data_ok ? m_rdata : 32'h0;
    assign busy      = (count != '0);

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter: per-cycle vector table plus a
// hand-written reset-mid-transaction and tie-break sequence.
module tb_sram_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_req, i_cancel, d_req, d_wr, m_addr_ok, m_data_ok;
    logic [31:0] i_addr, d_addr, d_wdata, m_rdata;
    logic [1:0]  d_size;
    logic [3:0]  d_wstrb;
    logic        i_addr_ok, i_data_ok, d_addr_ok, d_data_ok, m_req, m_wr, busy;
    logic [31:0] i_rdata, d_rdata, m_addr, m_wdata;
    logic [1:0]  m_size;
    logic [3:0]  m_wstrb;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sram_port_arbiter #(.OUTST(2), .AW(32)) dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_addr_ok(i_addr_ok), .i_data_ok(i_data_ok),
        .i_rdata(i_rdata), .i_cancel(i_cancel),
        .d_req(d_req), .d_wr(d_wr), .d_size(d_size), .d_addr(d_addr), .d_wstrb(d_wstrb),
        .d_wdata(d_wdata), .d_addr_ok(d_addr_ok), .d_data_ok(d_data_ok), .d_rdata(d_rdata),
        .m_req(m_req), .m_wr(m_wr), .m_size(m_size), .m_addr(m_addr), .m_wstrb(m_wstrb),
        .m_wdata(m_wdata), .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok), .m_rdata(m_rdata),
        .busy(busy)
    );

    // Downstream must never answer when nothing is outstanding.
    always @(posedge clk) begin
        if (!reset && m_data_ok)
            assert (busy) else $error("protocol: m_data_ok with no outstanding transaction");
    end

    typedef struct {
        string       name;
        logic        ir;  logic [31:0] ia;  logic ic;
        logic        dr;  logic dw; logic [1:0] dsz; logic [31:0] da; logic [3:0] dstb; logic [31:0] dwd;
        logic        mao; logic mdo; logic [31:0] mrd;
        logic        iao; logic ido; logic [31:0] ird;
        logic        dao; logic ddo; logic [31:0] drd;
        logic        mreq; logic mwr; logic [1:0] msz; logic [31:0] maddr; logic [3:0] mstb; logic [31:0] mwd;
        logic        bsy;
    } vec_t;

    localparam int NV = 37;
    vec_t vecs [NV];

    task automatic idle();
        i_req = 0; i_addr = 0; i_cancel = 0;
        d_req = 0; d_wr = 0; d_size = 0; d_addr = 0; d_wstrb = 0; d_wdata = 0;
        m_addr_ok = 0; m_data_ok = 0; m_rdata = 0;
    endtask

    task automatic apply(input vec_t v);
        i_req = v.ir; i_addr = v.ia; i_cancel = v.ic;
        d_req = v.dr; d_wr = v.dw; d_size = v.dsz; d_addr = v.da; d_wstrb = v.dstb; d_wdata = v.dwd;
        m_addr_ok = v.mao; m_data_ok = v.mdo; m_rdata = v.mrd;
    endtask

    function automatic logic [140:0] outs_now();
        return {i_addr_ok, i_data_ok, i_rdata, d_addr_ok, d_data_ok, d_rdata,
                m_req, m_wr, m_size, m_addr, m_wstrb, m_wdata, busy};
    endfunction

    task automatic cmp_vec(input string name, input logic [140:0] exp);
        logic [140:0] got;
        got = outs_now();
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: outputs got %h expected %h", name, got, exp);
        end
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    initial begin
        //          name        ir ia       ic dr dw dsz da       dstb dwd           mao mdo mrd            iao ido ird         dao ddo drd          mreq mwr msz maddr   mstb mwd          bsy
        vecs[0]  = '{"A_acc",    0, 0,       0, 1, 0, 2, 'h1000, 0,   0,            1,  0,  0,             0,  0,  0,          1,  0,  0,           1,   0,  2,  'h1000, 0,   0,           0};
        vecs[1]  = '{"A_wait",   0, 0,       0, 0, 0, 0, 0,      0,   0,            0,  0,  0,             0,  0,  0,          0,  0,  0,           0,   0,  0,  0,      0,   0,           1};
        vecs[2]  = '{"A_resp",   0, 0,       0, 0, 0, 0, 0,      0,   0,            0,  1,  'hDEADBEEF,    0,  0,  0,          0,  1,  'hDEADBEEF,  0,   0,  0,  0,      0,   0,           1};
        vecs[3]  = '{"A_idle",   0, 0,       0, 0, 0, 0, 0,      0,   0,            0,  0,  0,             0,  0,  0,          0,  0,  0,           0,   0,  0,  0,      0,   0,           0};
        vecs[4]  = '{"B_both",   1, 'h2000,  0, 1, 1, 2, 'h1004, 'hF, 'hCAFE0001,   1,  0,  0,             0,  0,  0,          1,  0,  0,           1,   1,  2,  'h1004, 'hF, 'hCAFE0001,  0};
        vecs[5]  = '{"B_inst",   1, 'h2000,  0, 0, 0, 0, 0,      0,   0,            1,  0,  0,             1,  0,  0,          0,  0,  0,           1,   0,  2,  'h2000, 0,   0,           1};
        vecs[6]  = '{"B_rsp_d",  0, 0,       0, 0, 0, 0, 0,      0,   0,            0,  1,  'hAAAA0001,    0,  0,  0,          0,  1,  'hAAAA0001,  0,   0,  0,  0,      0,   0,           1};
        vecs[7]  = '{"B_rsp_i",  0, 0,       0, 0, 0, 0, 0,      0,   0,            0,  1,  'hBBBB0002,    0,  1,  'hBBBB0002, 0,  0,  0,           0,   0,  0,  0,      0,   0,           1};
        vecs[8]  = '{"C_lock0",  1, 'h3000,  0, 0, 0, 0, 0,      0,   0,            0,  0,  0,             0,  0,  0,          0,  0,  0,           1,   0,  2,  'h3000, 0,   0,           0};
        vecs[9]  = '{"C_lock1",  1, 'h3000,  0, 1, 1, 1, 'h1008, 'h3, 'h1234,       0,  0,  0,             0,  0,  0,          0,  0,  0,           1,   0,  2,  'h3000, 0,   0,           0};
        vecs[10] = '{"C_lock2",  1, 'h3000,  0, 1, 1, 1, 'h1008, 'h3, 'h1234,       0,  0,  0,             0,  0,  0,          0,  0,  0,           1,   0,  2,  'h3000, 0,   0,           0};
        vecs[11] = '{"C_iacc",   1, 'h3000,  0, 1, 1, 1, 'h1008, 'h3, 'h1234,       1,  0,  0,             1,  0,  0,          0,  0,  0,           1,   0,  2,  'h3000, 0,   0,           0};
        vecs[12] = '{"C_dacc",   0, 0,       0, 1, 1, 1, 'h1008, 'h3, 'h1234,       1,  0,  0,             0,  0,  0,          1,  0,  0,           1,   1,  1,  'h1008, 'h3, 'h1234,      1};
        vecs[13] = '{"C_rsp_i",  0, 0,       0, 0, 0, 0, 0,      0,   0,            0,  1,  'h55,          0,  1,  'h55,       0,  0,  0,           0,   0,  0,  0,      0,   0,           1};
        vecs[14] = '{"C_rsp_d",  0, 0,       0, 0, 0, 0, 0,      0,   0,            0,  1,  'h66,          0,  0,  0,          0,  1,  'h66,        0,   0,  0,  0,      0,   0,           1};
        vecs[15] = '{"D_i0",     1, 'h4000,  0, 0, 0, 0, 0,      0,   0,            1,  0,  0,             1,  0,  0,          0,  0,  0,           1,   0,  2,  'h4000, 0,   0,           0};
        vecs[16] = '{"D_i1",     1, 'h4004,  0, 0, 0, 0, 0,      0,   0,            1,  0,  0,             1,  0,  0,          0,  0,  0,           1,   0,  2,  'h4004, 0,   0,           1};
        vecs[17] = '{"D_full",   0, 0,       0, 1, 0, 0, 'h100C, 'h1, 0,            1,  0,  0,             0,  0,  0,          0,  0,  0,           0,   0,  0,  0,      0,   0,           1};
        vecs[18] = '{"D_pop",    0, 0,       0, 1, 0, 0, 'h100C, 'h1, 0,            1,  1,  'h77,          0,  1,  'h77,       0,  0,  0,           0,   0,  0,  0,      0,   0,           1};
        vecs[19] = '{"D_gnt",    0, 0,       0, 1, 0, 0, 'h100C, 'h1, 0,            1,  0,  0,             0,  0,  0,          1,  0,  0,           1,   0,  0,  'h100C, 'h1, 0,           1};
        vecs[20] = '{"D_rsp_i",  0, 0,       0, 0, 0, 0, 0,      0,   0,            0,  1,  'h88,          0,  1,  'h88,       0,  0,  0,           0,   0,  0,  0,      0,   0,           1};
        vecs[21] = '{"D_rsp_d",  0, 0,       0, 0, 0, 0, 0,      0,   0,            0,  1,  'h99,          0,  0,  0,          0,  1,  'h99,        0,   0,  0,  0,      0,   0,           1};
        vecs[22] = '{"E_i0",     1, 'h5000,  0, 0, 0, 0, 0,      0,   0,            1,  0,  0,             1,  0,  0,          0,  0,  0,           1,   0,  2,  'h5000, 0,   0,           0};
        vecs[23] = '{"E_i1",     1, 'h5004,  0, 0, 0, 0, 0,      0,   0,            1,  0,  0,             1,  0,  0,          0,  0,  0,           1,   0,  2,  'h5004, 0,   0,           1};
        vecs[24] = '{"E_cancel", 0, 0,       1, 0, 0, 0, 0,      0,   0,            0,  0,  0,             0,  0,  0,          0,  0,  0,           0,   0,  0,  0,      0,   0,           1};
        vecs[25] = '{"E_drop0",  0, 0,       0, 0, 0, 0, 0,      0,   0,            0,  1,  'h11,          0,  0,  0,          0,  0,  0,           0,   0,  0,  0,      0,   0,           1};
        vecs[26] = '{"E_drop1",  0, 0,       0, 0, 0, 0, 0,      0,   0,            0,  1,  'h22,          0,  0,  0,          0,  0,  0,           0,   0,  0,  0,      0,   0,           1};
        vecs[27] = '{"E_i2",     1, 'h5008,  0, 0, 0, 0, 0,      0,   0,            1,  0,  0,             1,  0,  0,          0,  0,  0,           1,   0,  2,  'h5008, 0,   0,           0};
        vecs[28] = '{"E_rsp",    0, 0,       0, 0, 0, 0, 0,      0,   0,            0,  1,  'h33,          0,  1,  'h33,       0,  0,  0,           0,   0,  0,  0,      0,   0,           1};
        vecs[29] = '{"E_idle",   0, 0,       0, 0, 0, 0, 0,      0,   0,            0,  0,  0,             0,  0,  0,          0,  0,  0,           0,   0,  0,  0,      0,   0,           0};
        vecs[30] = '{"E_accxl",  1, 'h6000,  1, 0, 0, 0, 0,      0,   0,            1,  0,  0,             1,  0,  0,          0,  0,  0,           1,   0,  2,  'h6000, 0,   0,           0};
        vecs[31] = '{"E_dacc",   0, 0,       0, 1, 0, 2, 'h1010, 0,   0,            1,  0,  0,             0,  0,  0,          1,  0,  0,           1,   0,  2,  'h1010, 0,   0,           1};
        vecs[32] = '{"E_fulldr", 1, 'h6004,  0, 0, 0, 0, 0,      0,   0,            1,  1,  'h44,          0,  0,  0,          0,  0,  0,           0,   0,  0,  0,      0,   0,           1};
        vecs[33] = '{"E_i3",     1, 'h6004,  0, 0, 0, 0, 0,      0,   0,            1,  0,  0,             1,  0,  0,          0,  0,  0,           1,   0,  2,  'h6004, 0,   0,           1};
        vecs[34] = '{"E_rsp_d",  0, 0,       0, 0, 0, 0, 0,      0,   0,            0,  1,  'h45,          0,  0,  0,          0,  1,  'h45,        0,   0,  0,  0,      0,   0,           1};
        vecs[35] = '{"E_popxl",  0, 0,       1, 0, 0, 0, 0,      0,   0,            0,  1,  'h46,          0,  0,  0,          0,  0,  0,           0,   0,  0,  0,      0,   0,           1};
        vecs[36] = '{"E_end",    0, 0,       0, 0, 0, 0, 0,      0,   0,            0,  0,  0,             0,  0,  0,          0,  0,  0,           0,   0,  0,  0,      0,   0,           0};

        reset = 1'b1;
        idle();
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        cmp_vec("reset", '0);

        for (int k = 0; k < NV; k++) begin
            @(posedge clk);
            #1 apply(vecs[k]);
            @(negedge clk);
            cmp_vec(vecs[k].name, {vecs[k].iao, vecs[k].ido, vecs[k].ird, vecs[k].dao, vecs[k].ddo, vecs[k].drd,
                                   vecs[k].mreq, vecs[k].mwr, vecs[k].msz, vecs[k].maddr, vecs[k].mstb,
                                   vecs[k].mwd, vecs[k].bsy});
        end

        // Reset with two fetches in flight, then a data access must route cleanly.
        @(posedge clk);
        #1 idle(); i_req = 1; i_addr = 32'h7000; m_addr_ok = 1;
        @(negedge clk);
        chk("R_i0_ok", {31'h0, i_addr_ok}, 32'h1);
        @(posedge clk);
        #1 i_addr = 32'h7004;
        @(negedge clk);
        chk("R_busy1", {31'h0, busy}, 32'h1);
        @(posedge clk);
        #1 idle(); reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        cmp_vec("R_clear", '0);
        @(posedge clk);
        #1 d_req = 1; d_addr = 32'h1020; d_size = 2; m_addr_ok = 1;
        @(negedge clk);
        chk("R_dacc", {31'h0, d_addr_ok}, 32'h1);
        chk("R_maddr", m_addr, 32'h1020);
        @(posedge clk);
        #1 idle(); m_data_ok = 1; m_rdata = 32'hABCD1234;
        @(negedge clk);
        chk("R_drsp", {31'h0, d_data_ok}, 32'h1);
        chk("R_drdata", d_rdata, 32'hABCD1234);
        chk("R_irsp", {31'h0, i_data_ok}, 32'h0);
        @(posedge clk);
        #1 idle();
        @(negedge clk);
        chk("R_busy0", {31'h0, busy}, 32'h0);

        // Tie after a data accept: fixed priority keeps data, round robin picks inst.
        @(posedge clk);
        #1 i_req = 1; i_addr = 32'h8000; d_req = 1; d_addr = 32'h1030; d_size = 2; m_addr_ok = 1;
        @(negedge clk);
`ifdef ARB_ROUND_ROBIN_EN
        chk("T_tie_d", {31'h0, d_addr_ok}, 32'h0);
        chk("T_tie_i", {31'h0, i_addr_ok}, 32'h1);
        chk("T_tie_addr", m_addr, 32'h8000);
`else
        chk("T_tie_d", {31'h0, d_addr_ok}, 32'h1);
        chk("T_tie_i", {31'h0, i_addr_ok}, 32'h0);
        chk("T_tie_addr", m_addr, 32'h1030);
`endif
        @(posedge clk);
        #1 idle();
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
